// File: rtl/mux_arbiter.sv
// rtl/mux_arbiter.sv - packet-level round-robin arbiter driving a 2:1 router output mux
// Locks one port per HEAD..TAIL packet; a flit-count watchdog force-releases runaway packets.
module mux_arbiter #(
  parameter int FLITW  = 66,
  parameter int MAXLEN = 32,
  parameter int CNTW   = 6
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [FLITW-1:0] idata_0,
  input  logic             ivalid_0,
  input  logic [FLITW-1:0] idata_1,
  input  logic             ivalid_1,
  input  logic             oready,
  output logic [1:0]       sel,
  output logic             iack_0,
  output logic             iack_1,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2} state_t;

  localparam logic [1:0]      T_HEAD  = 2'b01;
  localparam logic [1:0]      T_TAIL  = 2'b11;
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(MAXLEN);

  state_t          state_q, state_d;
  logic            ptr_q, ptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            err_q, err_d;
  logic [1:0]      sel_q, sel_d;
  logic            busy_q, busy_d;

  logic [1:0] type_0, type_1, flit_type;
  logic       req_0, req_1, req_0_m, req_1_m;
  logic       xfer, rel;
  logic       unused_payload;

  assign type_0         = idata_0[FLITW-1:FLITW-2];
  assign type_1         = idata_1[FLITW-1:FLITW-2];
  assign req_0          = ivalid_0 && (type_0 == T_HEAD);
  assign req_1          = ivalid_1 && (type_1 == T_HEAD);
  assign cnt_inc        = cnt_q + CNTW'(1);
  assign unused_payload = ^{idata_0[FLITW-3:0], idata_1[FLITW-3:0]};

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    iack_0    = 1'b0;
    iack_1    = 1'b0;
    xfer      = 1'b0;
    rel       = 1'b0;
    flit_type = 2'b00;
    req_0_m   = req_0;
    req_1_m   = req_1;

    case (state_q)
      LOCK0: begin
        xfer      = ivalid_0 && oready;
        iack_0    = xfer;
        flit_type = type_0;
        // a flit consumed this cycle cannot also open the next packet
        if (xfer) req_0_m = 1'b0;
      end
      LOCK1: begin
        xfer      = ivalid_1 && oready;
        iack_1    = xfer;
        flit_type = type_1;
        if (xfer) req_1_m = 1'b0;
      end
      default: ;
    endcase

    if (xfer) begin
      cnt_d = cnt_inc;
      if (flit_type == T_TAIL) begin
        rel = 1'b1;
      end else if (cnt_inc == CNT_MAX) begin
        rel   = 1'b1;
        err_d = 1'b1;
      end
    end

    // release re-arbitrates on the same edge with the rotated pointer
    if ((state_q != LOCK0 && state_q != LOCK1) || rel) begin
      ptr_d = rel ? (state_q == LOCK0) : ptr_q;
      if (req_0_m && (!req_1_m || !ptr_d)) state_d = LOCK0;
      else if (req_1_m)                    state_d = LOCK1;
      else                                 state_d = IDLE;
      if (state_d != IDLE) cnt_d = '0;
    end

    case (state_d)
      LOCK0:   sel_d = 2'b01;
      LOCK1:   sel_d = 2'b10;
      default: sel_d = 2'b00;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      sel_q   <= 2'b00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
    end
  end

  assign sel  = sel_q;
  assign busy = busy_q;
  assign err  = err_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// tb/tb_mux_arbiter.sv - scoreboard bench for mux_arbiter
module tb_mux_arbiter;
  localparam int FLITW  = 66;
  localparam int MAXLEN = 32;
  localparam int CNTW   = 6;
  localparam int BUDGET = 2000;

  logic             clk = 1'b0;
  logic             rst_;
  logic [FLITW-1:0] idata_0, idata_1;
  logic             ivalid_0, ivalid_1, oready;
  logic [1:0]       sel;
  logic             iack_0, iack_1, busy, err;

  always #5 clk = ~clk;

  mux_arbiter #(.FLITW(FLITW), .MAXLEN(MAXLEN), .CNTW(CNTW)) dut (
    .clk(clk), .rst_(rst_),
    .idata_0(idata_0), .ivalid_0(ivalid_0),
    .idata_1(idata_1), .ivalid_1(ivalid_1),
    .oready(oready), .sel(sel),
    .iack_0(iack_0), .iack_1(iack_1),
    .busy(busy), .err(err)
  );

  int n_cmp = 0, n_bad = 0;
  int n_ack0 = 0, n_ack1 = 0, n_err = 0;
  bit ack0_s = 1'b0, ack1_s = 1'b0, sel01_seen = 1'b0;
  int seq = 0;
  logic [FLITW-1:0] tx0[$], tx1[$];
  logic [FLITW:0]   sb[$];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mk_pkt(input bit port, input int len, input bit tail, input int n_exp);
    for (int k = 0; k < len; k++) begin
      logic [1:0]       t;
      logic [FLITW-1:0] f;
      t = (k == 0) ? 2'b01 : ((tail && k == len - 1) ? 2'b11 : 2'b10);
      seq++;
      f = {t, (FLITW-2)'(seq)};
      if (port) tx1.push_back(f);
      else      tx0.push_back(f);
      if (k < n_exp) sb.push_back({port, f});
    end
  endtask

  task automatic wait_acks(input bit port, input int target, input string tag);
    int b = 0;
    while ((port ? n_ack1 : n_ack0) < target && b < BUDGET) begin
      @(negedge clk); #1;
      b++;
    end
    check_eq(tag, (b >= BUDGET), 0);
  endtask

  task automatic sb_compare(input bit port, input logic [FLITW-1:0] d);
    if (sb.size() == 0) check_eq("sb_underflow", {port, d}, 0);
    else                check_eq("flit", {port, d}, sb.pop_front());
  endtask

  // senders: hold the head flit until it is seen acked
  initial begin
    ivalid_0 = 1'b0; ivalid_1 = 1'b0; idata_0 = '0; idata_1 = '0;
    forever begin
      @(posedge clk); #1;
      if (ack0_s && tx0.size() > 0) void'(tx0.pop_front());
      if (ack1_s && tx1.size() > 0) void'(tx1.pop_front());
      ivalid_0 = (tx0.size() > 0);
      idata_0  = ivalid_0 ? tx0[0] : '0;
      ivalid_1 = (tx1.size() > 0);
      idata_1  = ivalid_1 ? tx1[0] : '0;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      ack0_s = iack_0;
      ack1_s = iack_1;
      if (iack_0) begin n_ack0++; sb_compare(1'b0, idata_0); end
      if (iack_1) begin n_ack1++; sb_compare(1'b1, idata_1); end
      if (err) n_err++;
      if (sel == 2'b01) sel01_seen = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int base0, base1, snap, e0;
    rst_ = 1'b0; oready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_sel", sel, 2'b00);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_ack", {iack_0, iack_1}, 2'b00);
    rst_ = 1'b1;

    // tie after reset goes to port 0, then port 1 without a bubble
    mk_pkt(1'b0, 20, 1'b1, 20);
    mk_pkt(1'b1, 5, 1'b1, 5);
    @(negedge clk);
    @(negedge clk);
    check_eq("t1_sel_p0", sel, 2'b01);
    check_eq("t1_busy", busy, 1);
    wait_acks(1'b0, 20, "t1_p0_done");
    @(negedge clk);
    check_eq("t1_no_bubble", sel, 2'b10);
    wait_acks(1'b1, 5, "t1_p1_done");
    check_eq("t1_sb", sb.size(), 0);

    // port 1 streams ten packets alone
    base1 = n_ack1; base0 = n_ack0; sel01_seen = 1'b0;
    for (int p = 0; p < 10; p++) mk_pkt(1'b1, 22, 1'b1, 22);
    wait_acks(1'b1, base1 + 220, "t2_done");
    check_eq("t2_never_p0", sel01_seen, 0);
    check_eq("t2_no_ack0", n_ack0, base0);

    // back-pressure mid-packet
    base0 = n_ack0;
    mk_pkt(1'b0, 10, 1'b1, 10);
    wait_acks(1'b0, base0 + 4, "t3_first4");
    @(posedge clk); #2;
    oready = 1'b0;
    snap = n_ack0;
    repeat (5) @(negedge clk);
    check_eq("t3_stall_noack", n_ack0, snap);
    check_eq("t3_stall_sel", sel, 2'b01);
    @(posedge clk); #2;
    oready = 1'b1;
    wait_acks(1'b0, base0 + 10, "t3_resume");
    check_eq("t3_sb", sb.size(), 0);

    // watchdog on a packet with no TAIL, port 1 HEAD pending
    base0 = n_ack0; base1 = n_ack1; e0 = n_err;
    mk_pkt(1'b0, 40, 1'b0, MAXLEN);
    wait_acks(1'b0, base0 + 1, "t4_start");
    mk_pkt(1'b1, 3, 1'b1, 3);
    wait_acks(1'b0, base0 + MAXLEN, "t4_maxlen");
    check_eq("t4_err_not_early", err, 0);
    @(negedge clk);
    check_eq("t4_err", err, 1);
    check_eq("t4_sel_after", sel, 2'b10);
    @(negedge clk);
    check_eq("t4_err_pulse", err, 0);
    wait_acks(1'b1, base1 + 3, "t4_p1_done");
    check_eq("t4_no_extra", n_ack0, base0 + MAXLEN);
    check_eq("t4_err_count", n_err - e0, 1);
    tx0.delete();
    repeat (2) @(negedge clk);

    // DATA on the non-granted port is ignored
    base0 = n_ack0; base1 = n_ack1;
    mk_pkt(1'b0, 6, 1'b1, 6);
    tx1.push_back({2'b10, (FLITW-2)'(64'hdead)});
    wait_acks(1'b0, base0 + 3, "t5_mid");
    check_eq("t5_sel", sel, 2'b01);
    check_eq("t5_no_ack1", iack_1, 0);
    wait_acks(1'b0, base0 + 6, "t5_done");
    @(negedge clk);
    check_eq("t5_idle", sel, 2'b00);
    check_eq("t5_ack1", n_ack1, base1);
    tx1.delete();
    repeat (2) @(negedge clk);

    // async reset mid-LOCK1, then tie must go back to port 0
    base1 = n_ack1;
    mk_pkt(1'b1, 10, 1'b1, 3);
    wait_acks(1'b1, base1 + 3, "t6_mid");
    rst_ = 1'b0;
    #1;
    check_eq("t6_async_sel", sel, 2'b00);
    check_eq("t6_async_busy", busy, 0);
    tx0.delete(); tx1.delete();
    repeat (2) @(negedge clk);
    check_eq("t6_sb", sb.size(), 0);
    rst_ = 1'b1;
    mk_pkt(1'b0, 4, 1'b1, 4);
    mk_pkt(1'b1, 4, 1'b1, 4);
    @(negedge clk);
    @(negedge clk);
    check_eq("t6_tie_p0", sel, 2'b01);
    wait_acks(1'b1, base1 + 7, "t6_done");
    check_eq("sb_drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
